// File: rtl/image_frame_sequencer.sv
// Single start/busy/done frame controller: reads every pixel, retires it PIPE_LAT cycles later, then streams file-order addresses.
// One pixel per cycle in PROC with no stalls; only the EMIT walk honours o_out_valid/i_out_ready backpressure.
module image_frame_sequencer #(
   parameter int WIDTH    = 768,
   parameter int HEIGHT   = 512,
   parameter int PIPE_LAT = 2,
   parameter int ADDR_W   = 20
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [2:0]        i_operation,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [2:0]        o_op_out,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_wb_en,
   output logic [ADDR_W-1:0] o_wb_addr,
   output logic              o_out_valid,
   output logic [ADDR_W-1:0] o_out_addr,
   input  logic              i_out_ready
);

   localparam int N  = WIDTH * HEIGHT;
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(HEIGHT);
   localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(HEIGHT - 1);
   localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
   localparam logic [YW-1:0]     Y_TOP     = YW'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PROC,
      S_DRAIN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              r_err;
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [ADDR_W-1:0] r_out_addr;
   logic              r_dl_vld  [PIPE_LAT];
   logic [ADDR_W-1:0] r_dl_addr [PIPE_LAT];

   logic w_op_valid;
   logic w_accept;
   logic w_emit_last;
   logic w_last_wb;

   assign w_op_valid  = (i_operation != 3'd0) && (i_operation != 3'd7);
   assign w_emit_last = (r_x == X_LAST) && (r_y == '0);
   assign w_last_wb   = o_wb_en && (o_wb_addr == LAST_ADDR);

   assign o_err      = r_err;
   assign o_op_out   = r_op;
   assign o_rd_addr  = r_rd_addr;
   assign o_out_addr = r_out_addr;
   assign o_wb_en    = r_dl_vld[PIPE_LAT-1];
   assign o_wb_addr  = r_dl_addr[PIPE_LAT-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_rd_en     = 1'b0;
      o_out_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && w_op_valid) begin
               w_next = S_PROC;
            end
         end
         S_PROC: begin
            o_busy  = 1'b1;
            o_rd_en = 1'b1;
            if (r_rd_addr == LAST_ADDR) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (w_last_wb) begin
               w_next = S_EMIT;
            end
         end
         S_EMIT: begin
            o_busy      = 1'b1;
            o_out_valid = 1'b1;
            w_accept    = i_out_ready;
            if (w_accept && w_emit_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            // busy drops together with the done pulse
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err      <= 1'b0;
         r_op       <= 3'd0;
         r_rd_addr  <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_out_addr <= '0;
      end else begin
         r_err <= (r_state == S_IDLE) && i_start && !w_op_valid;
         if ((r_state == S_IDLE) && i_start && w_op_valid) begin
            r_op <= i_operation;
         end
         if (o_rd_en) begin
            r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
         end
         // out_addr tracks x*HEIGHT+y incrementally so no multiplier is needed
         if ((r_state == S_DRAIN) && w_last_wb) begin
            r_x        <= '0;
            r_y        <= Y_TOP;
            r_out_addr <= TOP_ADDR;
         end else if (w_accept && !w_emit_last) begin
            if (r_x == X_LAST) begin
               r_x        <= '0;
               r_y        <= r_y - YW'(1);
               r_out_addr <= ADDR_W'(r_y) - ADDR_W'(1);
            end else begin
               r_x        <= r_x + XW'(1);
               r_out_addr <= r_out_addr + COL_STEP;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            r_dl_vld[i]  <= 1'b0;
            r_dl_addr[i] <= '0;
         end
      end else begin
         r_dl_vld[0]  <= o_rd_en;
         r_dl_addr[0] <= o_rd_addr;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_dl_vld[i]  <= r_dl_vld[i-1];
            r_dl_addr[i] <= r_dl_addr[i-1];
         end
      end
   end

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Bench for image_frame_sequencer: directed timing, backpressure, error/ignore, mid-frame reset and random-ready frames.
module tb_image_frame_sequencer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int PL = 2;
   localparam int AW = 20;
   localparam int N  = W * H;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start;
   logic [2:0]    i_operation;
   logic          i_out_ready;
   logic          o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid;
   logic [2:0]    o_op_out;
   logic [AW-1:0] o_rd_addr, o_wb_addr, o_out_addr;

   int checks   = 0;
   int failures = 0;
   int emit_q[$];

   always #5 i_clk = ~i_clk;

   image_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(PL), .ADDR_W(AW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_operation(i_operation),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_op_out(o_op_out),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr),
      .o_out_valid(o_out_valid), .o_out_addr(o_out_addr), .i_out_ready(i_out_ready)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid, o_op_out, o_rd_addr, o_wb_addr, o_out_addr} !== '0) begin
         failures++;
         $display("FAIL reset_held got busy=%b done=%b err=%b rd=%b wb=%b ov=%b op=%0d ra=%0d wa=%0d oa=%0d exp all 0",
                  o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid, o_op_out, o_rd_addr, o_wb_addr, o_out_addr);
      end
      i_rst_n = 1'b1;
      tick();
      checks++;
      if ({o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid, o_op_out, o_rd_addr, o_wb_addr, o_out_addr} !== '0) begin
         failures++;
         $display("FAIL reset_released got busy=%b done=%b err=%b rd=%b wb=%b ov=%b op=%0d exp all 0",
                  o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid, o_op_out);
      end
   endtask

   task automatic test_frame_directed();
      int   first_ov, done_at;
      logic e_rd, e_wb, e_ov, e_done, e_busy;
      first_ov = N + PL + 1;
      done_at  = 2 * N + PL + 1;
      i_operation = 3'd3; i_start = 1'b1; i_out_ready = 1'b1;
      tick();
      i_start = 1'b0; i_operation = 3'd0;
      for (int cyc = 1; cyc <= done_at + 2; cyc++) begin
         e_rd   = (cyc <= N);
         e_wb   = (cyc > PL) && (cyc <= N + PL);
         e_ov   = (cyc >= first_ov) && (cyc < done_at);
         e_done = (cyc == done_at);
         e_busy = (cyc < done_at);
         checks++;
         if ({o_rd_en, o_wb_en, o_out_valid, o_done, o_busy} !== {e_rd, e_wb, e_ov, e_done, e_busy}) begin
            failures++;
            $display("FAIL dir_strobes cyc=%0d got rd/wb/ov/done/busy=%b exp=%b", cyc,
                     {o_rd_en, o_wb_en, o_out_valid, o_done, o_busy}, {e_rd, e_wb, e_ov, e_done, e_busy});
         end
         if (e_rd) begin
            checks++;
            if (o_rd_addr !== AW'(cyc - 1)) begin
               failures++;
               $display("FAIL dir_rd_addr cyc=%0d got=%0d exp=%0d", cyc, o_rd_addr, cyc - 1);
            end
         end
         if (e_wb) begin
            checks++;
            if (o_wb_addr !== AW'(cyc - 1 - PL)) begin
               failures++;
               $display("FAIL dir_wb_addr cyc=%0d got=%0d exp=%0d", cyc, o_wb_addr, cyc - 1 - PL);
            end
         end
         if (e_ov) begin
            checks++;
            if (o_out_addr !== AW'(emit_q[cyc - first_ov])) begin
               failures++;
               $display("FAIL dir_out_addr cyc=%0d got=%0d exp=%0d", cyc, o_out_addr, emit_q[cyc - first_ov]);
            end
         end
         checks++;
         if (o_op_out !== 3'd3) begin
            failures++;
            $display("FAIL dir_op_out cyc=%0d got=%0d exp=3", cyc, o_op_out);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int idx, hold_left, done_cyc;
      bit triggered;
      idx = 0; hold_left = 0; done_cyc = -1; triggered = 1'b0;
      i_operation = 3'd1; i_start = 1'b1; i_out_ready = 1'b1;
      tick();
      i_start = 1'b0;
      for (int cyc = 1; cyc <= 2 * N + PL + 8; cyc++) begin
         if (hold_left > 0) begin
            checks++;
            if (o_out_valid !== 1'b1 || o_out_addr !== AW'(8)) begin
               failures++;
               $display("FAIL bp_hold cyc=%0d got ov=%b addr=%0d exp ov=1 addr=8", cyc, o_out_valid, o_out_addr);
            end
            hold_left--;
         end
         if (!triggered && o_out_valid && o_out_addr == AW'(8)) begin
            triggered = 1'b1;
            hold_left = 3;
         end
         i_out_ready = (hold_left == 0);
         if (o_out_valid && i_out_ready) begin
            checks++;
            if (idx >= N || o_out_addr !== AW'(emit_q[idx])) begin
               failures++;
               $display("FAIL bp_seq idx=%0d got=%0d exp=%0d", idx, o_out_addr, (idx < N) ? emit_q[idx] : -1);
            end
            idx++;
         end
         if (o_done) done_cyc = cyc;
         tick();
      end
      i_out_ready = 1'b1;
      checks++;
      if (!triggered || idx != N) begin
         failures++;
         $display("FAIL bp_count got triggered=%0d accepted=%0d exp triggered=1 accepted=%0d", triggered, idx, N);
      end
      checks++;
      if (done_cyc != 2 * N + PL + 1 + 3) begin
         failures++;
         $display("FAIL bp_done_cycle got=%0d exp=%0d", done_cyc, 2 * N + PL + 4);
      end
   endtask

   task automatic test_err_and_ignore();
      int done_cyc;
      i_start = 1'b1; i_operation = 3'd0;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL err_op0 got err=%b busy=%b exp err=1 busy=0", o_err, o_busy);
      end
      tick();
      checks++;
      if (o_err !== 1'b0) begin
         failures++;
         $display("FAIL err_pulse_width got err=%b exp 0", o_err);
      end
      i_start = 1'b1; i_operation = 3'd7;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_op_out !== 3'd1) begin
         failures++;
         $display("FAIL err_op7 got err=%b busy=%b op=%0d exp err=1 busy=0 op=1", o_err, o_busy, o_op_out);
      end
      i_start = 1'b1; i_operation = 3'd2;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_err !== 1'b0 || o_op_out !== 3'd2) begin
         failures++;
         $display("FAIL start_op2 got busy=%b err=%b op=%0d exp busy=1 err=0 op=2", o_busy, o_err, o_op_out);
      end
      repeat (4) tick();
      i_start = 1'b1; i_operation = 3'd5;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_op_out !== 3'd2 || o_rd_addr !== AW'(5) || o_err !== 1'b0) begin
         failures++;
         $display("FAIL ignore_busy_start got op=%0d ra=%0d err=%b exp op=2 ra=5 err=0", o_op_out, o_rd_addr, o_err);
      end
      i_out_ready = 1'b1;
      done_cyc = -1;
      for (int k = 0; k < 4 * N + 20 && done_cyc < 0; k++) begin
         if (o_done) done_cyc = k;
         tick();
      end
      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL err_drain_timeout got no done exp done within %0d cycles", 4 * N + 20);
      end
   endtask

   task automatic test_reset_mid_proc();
      int done_cyc;
      i_start = 1'b1; i_operation = 3'd4;
      tick();
      i_start = 1'b0;
      repeat (5) tick();
      checks++;
      if (o_rd_en !== 1'b1 || o_rd_addr !== AW'(5)) begin
         failures++;
         $display("FAIL pre_reset_proc got rd=%b ra=%0d exp rd=1 ra=5", o_rd_en, o_rd_addr);
      end
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_done, o_err, o_rd_en, o_wb_en, o_out_valid, o_op_out, o_rd_addr, o_wb_addr, o_out_addr} !== '0) begin
         failures++;
         $display("FAIL async_reset got busy=%b rd=%b wb=%b op=%0d ra=%0d wa=%0d exp all 0",
                  o_busy, o_rd_en, o_wb_en, o_op_out, o_rd_addr, o_wb_addr);
      end
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < PL + 3; k++) begin
         tick();
         checks++;
         if (o_wb_en !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet k=%0d got wb=%b busy=%b exp 0 0", k, o_wb_en, o_busy);
         end
      end
      i_start = 1'b1; i_operation = 3'd6; i_out_ready = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_rd_en !== 1'b1 || o_rd_addr !== '0 || o_op_out !== 3'd6) begin
         failures++;
         $display("FAIL restart_from_0 got rd=%b ra=%0d op=%0d exp rd=1 ra=0 op=6", o_rd_en, o_rd_addr, o_op_out);
      end
      repeat (PL) tick();
      checks++;
      if (o_wb_en !== 1'b1 || o_wb_addr !== '0) begin
         failures++;
         $display("FAIL restart_first_wb got wb=%b wa=%0d exp wb=1 wa=0", o_wb_en, o_wb_addr);
      end
      done_cyc = -1;
      for (int k = 0; k < 4 * N + 20 && done_cyc < 0; k++) begin
         if (o_done) done_cyc = k;
         tick();
      end
      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL restart_timeout got no done exp done within %0d cycles", 4 * N + 20);
      end
   endtask

   task automatic test_random_frames();
      int rd_exp, wb_exp, idx, stalls, done_cyc, cyc;
      logic [2:0] op;
      for (int f = 0; f < 4; f++) begin
         op = 3'(1 + $urandom_range(5));
         rd_exp = 0; wb_exp = 0; idx = 0; stalls = 0; done_cyc = -1; cyc = 1;
         i_start = 1'b1; i_operation = op; i_out_ready = 1'b1;
         tick();
         i_start = 1'b0; i_operation = 3'($urandom_range(7));
         while (cyc <= 2 * N + PL + 8 * N && done_cyc < 0) begin
            if (o_rd_en) begin
               checks++;
               if (o_rd_addr !== AW'(rd_exp)) begin
                  failures++;
                  $display("FAIL rnd_rd f=%0d cyc=%0d got=%0d exp=%0d", f, cyc, o_rd_addr, rd_exp);
               end
               rd_exp++;
            end
            if (o_wb_en) begin
               checks++;
               if (o_wb_addr !== AW'(wb_exp) || cyc != wb_exp + 1 + PL) begin
                  failures++;
                  $display("FAIL rnd_wb f=%0d cyc=%0d got=%0d exp=%0d at cyc %0d", f, cyc, o_wb_addr, wb_exp, wb_exp + 1 + PL);
               end
               wb_exp++;
            end
            i_out_ready = ($urandom_range(3) != 0);
            if (o_out_valid) begin
               if (i_out_ready) begin
                  checks++;
                  if (idx >= N || o_out_addr !== AW'(emit_q[idx])) begin
                     failures++;
                     $display("FAIL rnd_out f=%0d idx=%0d got=%0d exp=%0d", f, idx, o_out_addr, (idx < N) ? emit_q[idx] : -1);
                  end
                  idx++;
               end else begin
                  stalls++;
               end
            end
            if (o_done) begin
               done_cyc = cyc;
               checks++;
               if (o_busy !== 1'b0 || o_op_out !== op) begin
                  failures++;
                  $display("FAIL rnd_done_state f=%0d got busy=%b op=%0d exp busy=0 op=%0d", f, o_busy, o_op_out, op);
               end
            end
            tick();
            cyc++;
         end
         checks++;
         if (rd_exp != N || wb_exp != N || idx != N) begin
            failures++;
            $display("FAIL rnd_counts f=%0d got rd=%0d wb=%0d out=%0d exp %0d each", f, rd_exp, wb_exp, idx, N);
         end
         checks++;
         if (done_cyc != 2 * N + PL + 1 + stalls) begin
            failures++;
            $display("FAIL rnd_done_cycle f=%0d got=%0d exp=%0d", f, done_cyc, 2 * N + PL + 1 + stalls);
         end
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_operation = 3'd0; i_out_ready = 1'b0;
      for (int y = H - 1; y >= 0; y--) begin
         for (int x = 0; x < W; x++) begin
            emit_q.push_back(x * H + y);
         end
      end
      test_reset();
      test_frame_directed();
      test_backpressure();
      test_err_and_ignore();
      test_reset_mid_proc();
      test_random_frames();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/image_frame_sequencer.md
# image_frame_sequencer

- Controls one frame pass through the pixel-processing pipeline. On `start` it captures the operation code and sweeps every pixel address through the read → process → write-back path, one pixel per cycle.
- Once the last write-back has retired, it streams pixel addresses to the BMP writer in file order (bottom row first, left to right) under a valid/ready handshake, then pulses `done`.
- It sits between the testbench/host and the frame memory plus output writer. It replaces free-running counters with a single start/busy/done controller.

## Interface
- `WIDTH`, 768, image width in pixels
- `HEIGHT`, 512, image height in pixels
- `PIPE_LAT`, 2, cycles from `rd_en` to the matching `wb_en` (read register + process register); legal 1–8
- `ADDR_W`, 20, pixel address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin frame; sampled only in IDLE
- `operation`  in  3  op code: 1 bright, 2 dark, 3 invert, 4/5/6 red/green/blue tint
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last output address is accepted
- `err`  out  1  one-cycle pulse when `start` arrives in IDLE with `operation` 0 or 7
- `op_out`  out  3  operation latched at start; held stable until the next accepted start
- `rd_en`  out  1  frame memory read strobe
- `rd_addr`  out  ADDR_W  read address
- `wb_en`  out  1  write-back strobe to frame memory
- `wb_addr`  out  ADDR_W  write-back address
- `out_valid`  out  1  output address valid
- `out_addr`  out  ADDR_W  address of the next pixel for the BMP writer
- `out_ready`  in  1  writer accepts `out_addr` this cycle

## Operation
- Memory layout is column-major: addr = x*HEIGHT + y, with x in 0..WIDTH-1 and y in 0..HEIGHT-1. N = WIDTH*HEIGHT.
- States and transitions:
  - IDLE: on `start` with a valid op (1–6), latch `op_out` and go to PROC. With op 0 or 7, pulse `err` and stay in IDLE.
  - PROC: assert `rd_en`, with `rd_addr` = 0,1,…,N-1 on consecutive cycles and no gaps. After address N-1 is issued, go to DRAIN.
  - DRAIN: wait until the write-back for N-1 has been issued, then go to EMIT.
  - EMIT: `out_valid`=1. The address walks y = HEIGHT-1 down to 0 (outer loop) and x = 0 up to WIDTH-1 (inner loop).
    - The walk advances only on `out_valid & out_ready`.
    - Acceptance of x=WIDTH-1, y=0 moves to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Write-back path: `wb_en`/`wb_addr` are `rd_en`/`rd_addr` delayed by exactly PIPE_LAT cycles through a shift register. The write-back address therefore always equals the address read PIPE_LAT cycles earlier.
- `start` is ignored while `busy` is high. `err` is never raised when busy.
- Counters:
  - x counter: ceil(log2 WIDTH) bits; wraps to 0 at WIDTH-1 and decrements y.
  - y counter: ceil(log2 HEIGHT) bits; starts at HEIGHT-1.
  - `out_addr` = x*HEIGHT + y, computed into ADDR_W bits without overflow.
- Reset asserted at any time:
  - All state returns to IDLE immediately.
  - The delay line is cleared, so no `wb_en` appears after reset, even for reads already in flight.
  - The frame restarts from addr 0 on the next start.

## Timing
- Reset values: `busy`, `done`, `err`, `rd_en`, `wb_en`, `out_valid` = 0; `rd_addr`, `wb_addr`, `out_addr` = 0; `op_out` = 0.
- `start` high at edge t (IDLE): `busy` and `rd_en` high from t+1 with `rd_addr`=0; last read at t+N.
- First `wb_en` at t+1+PIPE_LAT; last at t+N+PIPE_LAT. `rd_en` and `wb_en` overlap in PROC.
- EMIT begins the cycle after the last `wb_en`: `out_valid` rises at t+N+PIPE_LAT+1.
- `out_addr` holds while `out_valid & ~out_ready`.
- With `out_ready` tied high, `out_addr` changes every cycle. `done` rises the cycle after the final accept and `busy` falls the same cycle as `done`.
- `err` is registered: it is high the cycle after the invalid start.

## Test plan
- Reset: deassert `rst` low→high mid-simulation → every output is 0 and the block is in IDLE; `start` then works normally.
- WIDTH=4, HEIGHT=3, PIPE_LAT=2, op=3: `start` at cycle 0 → `rd_en` cycles 1–12 with addr 0..11; `wb_en` cycles 3–14 with addr 0..11; `op_out`=3 throughout.
- Same config, `out_ready`=1: `out_addr` sequence is 2,5,8,11,1,4,7,10,0,3,6,9, starting at cycle 15; `done` pulses at cycle 27; `busy` is 0 at cycle 27.
- Backpressure: drop `out_ready` for 3 cycles while `out_addr`=8 → `out_addr` holds at 8 and `out_valid` stays 1; the sequence resumes at 11 and `done` is delayed by 3 cycles.
- `start` with op=0 in IDLE → `err` pulse, `busy` stays 0; `start` with op=5 during PROC → ignored, `op_out` unchanged.
- Assert `rst` (low) at cycle 6 of PROC → all outputs 0 next sample and no `wb_en` afterwards; a new `start` reads from addr 0.
